mc_datapath: RTL and testbench

- Multicycle successor to the single-cycle ARM datapath: one shared, unified instruction/data memory port with a variable-latency request/ready handshake.
- An internal sequencer FSM replaces the external single-cycle control, so each instruction takes several clock cycles.
- Sits between the top-level CPU wrapper and a single memory model (or a cache).
- Instruction subset: ADD, SUB, AND, ORR (immediate or register operand, optional S), LDR/STR with imm12 offset (P=1, W=0, U honoured), and B. All 15 condition codes are supported.

---
 rtl/mc_datapath.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
//   Multicycle ARM-subset datapath with an internal sequencer FSM and one
//   unified instruction/data memory port. Handles ADD/SUB/AND/ORR (immediate
//   or register operand, optional S), LDR/STR with a 12-bit immediate offset
//   and B, all under condition codes.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   mem_req    memory request valid (registered)
//   mem_we     1 = write, 0 = read, valid while mem_req=1
//   mem_addr   word-aligned byte address (low ADDR_W bits of the address)
//   mem_wdata  store data
//   mem_rdata  read data, sampled on the edge where mem_ready=1
//   mem_ready  completes the outstanding request
//   pc         address of the next fetch
//   flags      {N,Z,C,V}
//   halted     sticky, set when an unsupported instruction is decoded
//   state      current sequencer state encoding
// ---------------------------------------------------------------------------
module mc_datapath #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] PC_OFFSET = 32'd8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [3:0]        flags,
    output logic              halted,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWR  = 4'd6,
        S_MEMWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [3:0]  flags_q;
    logic [31:0] rf [0:14];
    logic [31:0] ir;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] data_reg;

    assign state = state_q;
    assign pc    = pc_q;
    assign flags = flags_q;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_sel;
    logic [3:0] cmd;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic       up_bit;

    assign cond    = ir[31:28];
    assign op      = ir[27:26];
    assign imm_sel = ir[25];
    assign cmd     = ir[24:21];
    assign s_bit   = ir[20];
    assign rn      = ir[19:16];
    assign rd      = ir[15:12];
    assign rm      = ir[3:0];
    assign up_bit  = ir[23];

    // During DECODE pc already points past the instruction, so an R15 read
    // adds PC_OFFSET-4 to land at instruction address + PC_OFFSET.
    logic [31:0] pc_read;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] rd_val;

    always_comb begin
        pc_read = pc_q + PC_OFFSET - 32'd4;
        rn_val  = (rn == 4'hF) ? pc_read : rf[rn];
        rm_val  = (rm == 4'hF) ? pc_read : rf[rm];
        rd_val  = (rd == 4'hF) ? pc_read : rf[rd];
    end

    // Condition check against the current flags
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = ~flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = ~flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = ~flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = ~flag_v;
            4'h8: cond_pass = flag_c & ~flag_z;
            4'h9: cond_pass = ~flag_c | flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
            4'hD: cond_pass = flag_z | (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic cmd_ok;
    assign cmd_ok = (cmd == 4'b0100) || (cmd == 4'b0010) ||
                    (cmd == 4'b0000) || (cmd == 4'b1100);

    // Immediate operand: imm8 rotated right by twice the rotate field.
    // A shift of 32 yields zero, which covers the no-rotation case.
    logic [31:0] imm8_ext;
    logic [4:0]  rot_amt;
    logic [31:0] imm_rot;
    logic [31:0] src_b;

    always_comb begin
        imm8_ext = {24'b0, ir[7:0]};
        rot_amt  = {ir[11:8], 1'b0};
        imm_rot  = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));
        src_b    = imm_sel ? imm_rot : b_reg;
    end

    // ALU; SUB carry is the inverted borrow from a + ~b + 1
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        alu_arith;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_arith = 1'b0;
        case (cmd)
            4'b0100: begin
                {alu_c, alu_res} = {1'b0, a_reg} + {1'b0, src_b};
                alu_v     = (a_reg[31] == src_b[31]) && (alu_res[31] != a_reg[31]);
                alu_arith = 1'b1;
            end
            4'b0010: begin
                {alu_c, alu_res} = {1'b0, a_reg} + {1'b0, ~src_b} + 33'd1;
                alu_v     = (a_reg[31] != src_b[31]) && (alu_res[31] != a_reg[31]);
                alu_arith = 1'b1;
            end
            4'b1100: alu_res = a_reg | src_b;
            default: alu_res = a_reg & src_b;
        endcase
    end

    // Load/store effective address and branch target
    logic [31:0] mem_ea;
    logic [31:0] br_target;

    always_comb begin
        mem_ea    = up_bit ? (a_reg + {20'b0, ir[11:0]}) : (a_reg - {20'b0, ir[11:0]});
        br_target = pc_q + 32'd4 + {{6{ir[23]}}, ir[23:0], 2'b00};
    end

    // Sequencer. Memory-port outputs are registered: every transition into
    // a memory state loads the request that state needs, so the bus is
    // already valid in the first cycle of that state and holds until ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            flags_q   <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_out   <= '0;
            data_reg  <= '0;
            for (int i = 0; i < 15; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir      <= mem_rdata;
                        pc_q    <= pc_q + 32'd4;
                        mem_req <= 1'b0;
                        state_q <= S_DECODE;
                    end else begin
                        // Only the first cycle after reset arrives here idle
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_q[ADDR_W-1:0];
                    end
                end
                S_DECODE: begin
                    a_reg <= rn_val;
                    b_reg <= (op == 2'b01) ? rd_val : rm_val;
                    if (cond == 4'hF) begin
                        halted  <= 1'b1;
                        state_q <= S_HALT;
                    end else if (!cond_pass) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_q[ADDR_W-1:0];
                        state_q  <= S_FETCH;
                    end else begin
                        case (op)
                            2'b00: begin
                                if (cmd_ok) begin
                                    state_q <= S_EXEC;
                                end else begin
                                    halted  <= 1'b1;
                                    state_q <= S_HALT;
                                end
                            end
                            2'b01: state_q <= S_MEMADR;
                            2'b10: state_q <= S_BRANCH;
                            default: begin
                                halted  <= 1'b1;
                                state_q <= S_HALT;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (s_bit) begin
                        if (alu_arith) begin
                            flags_q <= {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
                        end else begin
                            flags_q <= {alu_res[31], (alu_res == 32'd0), 2'b00};
                        end
                    end
                    state_q <= S_ALUWB;
                end
                S_ALUWB: begin
                    mem_req <= 1'b1;
                    mem_we  <= 1'b0;
                    if (rd == 4'hF) begin
                        pc_q     <= alu_out;
                        mem_addr <= alu_out[ADDR_W-1:0];
                    end else begin
                        rf[rd]   <= alu_out;
                        mem_addr <= pc_q[ADDR_W-1:0];
                    end
                    state_q <= S_FETCH;
                end
                S_MEMADR: begin
                    alu_out  <= mem_ea;
                    mem_req  <= 1'b1;
                    mem_addr <= mem_ea[ADDR_W-1:0];
                    if (s_bit) begin
                        mem_we  <= 1'b0;
                        state_q <= S_MEMRD;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_wdata <= b_reg;
                        state_q   <= S_MEMWR;
                    end
                end
                S_MEMRD: begin
                    if (mem_req && mem_ready) begin
                        data_reg <= mem_rdata;
                        mem_req  <= 1'b0;
                        state_q  <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    mem_req <= 1'b1;
                    mem_we  <= 1'b0;
                    if (rd == 4'hF) begin
                        pc_q     <= data_reg;
                        mem_addr <= data_reg[ADDR_W-1:0];
                    end else begin
                        rf[rd]   <= data_reg;
                        mem_addr <= pc_q[ADDR_W-1:0];
                    end
                    state_q <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_req && mem_ready) begin
                        mem_we   <= 1'b0;
                        mem_addr <= pc_q[ADDR_W-1:0];
                        state_q  <= S_FETCH;
                    end
                end
                S_BRANCH: begin
                    pc_q     <= br_target;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= br_target[ADDR_W-1:0];
                    state_q  <= S_FETCH;
                end
                S_HALT: begin
                    halted  <= 1'b1;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    halted  <= 1'b1;
                    mem_req <= 1'b0;
                    state_q <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// ---------------------------------------------------------------------------
// tb_mc_datapath
//   Self-checking bench for mc_datapath. A behavioural memory answers the
//   request/ready port with a programmable wait count. Each program's
//   expected bus transactions (kind, address, store data, FSM state and
//   cycles since the previous completion) are queued up front and popped as
//   the DUT completes each transaction.
// ---------------------------------------------------------------------------
module tb_mc_datapath;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic        halted;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  st;
        int          gap;
    } txn_t;

    txn_t        sb[$];
    logic [31:0] mem [0:255];
    int          latency = 0;
    bit          stall = 1'b0;
    int          fetch_count = 0;
    int          cyc = 0;
    int          last_cyc = 0;

    mc_datapath #(
        .RESET_PC (RPC),
        .ADDR_W   (32),
        .PC_OFFSET(32'd8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .flags    (flags),
        .halted   (halted),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expFetch(input logic [31:0] addr, input int gap);
        txn_t t;
        t.we = 1'b0; t.addr = addr; t.wdata = '0; t.st = 4'd0; t.gap = gap;
        sb.push_back(t);
    endtask

    task automatic expRead(input logic [31:0] addr, input int gap);
        txn_t t;
        t.we = 1'b0; t.addr = addr; t.wdata = '0; t.st = 4'd5; t.gap = gap;
        sb.push_back(t);
    endtask

    task automatic expWrite(input logic [31:0] addr, input logic [31:0] data, input int gap);
        txn_t t;
        t.we = 1'b1; t.addr = addr; t.wdata = data; t.st = 4'd6; t.gap = gap;
        sb.push_back(t);
    endtask

    task automatic putWord(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    // Memory model: decides mem_ready on the falling edge so the DUT sees
    // it on the following rising edge; checks request stability while held.
    initial begin : responder
        bit          in_req;
        int          wait_cnt;
        logic [31:0] hold_addr;
        logic [31:0] hold_wdata;
        logic        hold_we;
        txn_t        e;
        in_req = 1'b0;
        wait_cnt = 0;
        hold_addr = '0;
        hold_wdata = '0;
        hold_we = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                in_req = 1'b0;
                wait_cnt = 0;
                mem_ready = 1'b0;
            end else if (mem_req === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_cnt = 0;
                    hold_addr = mem_addr;
                    hold_we = mem_we;
                    hold_wdata = mem_wdata;
                end else begin
                    checkOutput("hold_addr", mem_addr, hold_addr);
                    checkOutput("hold_we", {31'b0, mem_we}, {31'b0, hold_we});
                    if (hold_we) checkOutput("hold_wdata", mem_wdata, hold_wdata);
                end
                if (stall || wait_cnt < latency) begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    in_req = 1'b0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput("txn_we", {31'b0, mem_we}, {31'b0, e.we});
                        checkOutput("txn_addr", mem_addr, e.addr);
                        checkOutput("txn_state", {28'b0, state}, {28'b0, e.st});
                        if (e.we) checkOutput("txn_wdata", mem_wdata, e.wdata);
                        if (e.gap >= 0) checkOutput("txn_gap", cyc - last_cyc, e.gap);
                    end
                    if (mem_we) begin
                        mem[mem_addr[9:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[9:2]];
                        if (state == 4'd0) fetch_count++;
                    end
                    last_cyc = cyc;
                end
            end else begin
                in_req = 1'b0;
                mem_ready = 1'b0;
            end
        end
    end

    // Holds the DUT in reset, checks reset values and releases it
    task automatic applyStimulus(input int lat, input bit st);
        @(negedge clk);
        #2 reset_n = 1'b0;
        latency = lat;
        stall = st;
        fetch_count = 0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_state", {28'b0, state}, 32'd0);
        checkOutput("rst_pc", pc, RPC);
        checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_flags", {28'b0, flags}, 32'd0);
        checkOutput("rst_halted", {31'b0, halted}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic waitFetches(input int n, input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (fetch_count >= n) break;
        end
        if (fetch_count < n) checkOutput(tag, fetch_count, n);
    endtask

    task automatic waitHalt(input string tag);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (halted === 1'b1) break;
        end
        checkOutput(tag, {31'b0, halted}, 32'd1);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        #1 reset_n = 1'b0;

        // Program 1: ALU ops, flags, stores, a not-taken BEQ and a halt
        clearMem();
        putWord(32'h100, 32'hE3801005);   // ORR  R1,R0,#5
        putWord(32'h104, 32'hE2512005);   // SUBS R2,R1,#5
        putWord(32'h108, 32'hE5802008);   // STR  R2,[R0,#8]
        putWord(32'h10C, 32'hE380747F);   // ORR  R7,R0,#0x7F000000
        putWord(32'h110, 32'hE0978007);   // ADDS R8,R7,R7
        putWord(32'h114, 32'hE5808010);   // STR  R8,[R0,#0x10]
        putWord(32'h118, 32'hE2503001);   // SUBS R3,R0,#1
        putWord(32'h11C, 32'h0A000001);   // BEQ  (not taken)
        putWord(32'h120, 32'hEC000000);   // unsupported -> halt
        sb.delete();
        expFetch(32'h100, -1);
        expFetch(32'h104, 4);
        expFetch(32'h108, 4);
        expWrite(32'h008, 32'h0000_0000, 3);
        expFetch(32'h10C, 1);
        expFetch(32'h110, 4);
        expFetch(32'h114, 4);
        expWrite(32'h010, 32'hFE00_0000, 3);
        expFetch(32'h118, 1);
        expFetch(32'h11C, 4);
        expFetch(32'h120, 2);
        applyStimulus(0, 1'b0);
        waitFetches(1, "p1_first_fetch");
        checkOutput("p1_first_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("p1_pc_after_fetch", pc, 32'h104);
        checkOutput("p1_state_decode", {28'b0, state}, 32'd1);
        waitFetches(3, "p1_wait_subs");
        checkOutput("p1_flags_subs", {28'b0, flags}, 32'b0110);
        waitFetches(6, "p1_wait_adds");
        checkOutput("p1_flags_adds", {28'b0, flags}, 32'b1001);
        waitHalt("p1_halt");
        checkOutput("p1_state_halt", {28'b0, state}, 32'd9);
        checkOutput("p1_pc_halt", pc, 32'h124);
        checkOutput("p1_flags_final", {28'b0, flags}, 32'b1000);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("p1_halt_sticky", {31'b0, halted}, 32'd1);
        checkOutput("p1_halt_state", {28'b0, state}, 32'd9);
        checkOutput("p1_halt_noreq", {31'b0, mem_req}, 32'd0);
        checkOutput("p1_sb_empty", sb.size(), 32'd0);

        // Program 2: loads/stores with three wait states on every request
        clearMem();
        putWord(32'h100, 32'hE3801005);   // ORR R1,R0,#5
        putWord(32'h104, 32'hE5801008);   // STR R1,[R0,#8]
        putWord(32'h108, 32'hE5903008);   // LDR R3,[R0,#8]
        putWord(32'h10C, 32'hE3804D01);   // ORR R4,R0,#0x40 (rotated imm)
        putWord(32'h110, 32'hE5043030);   // STR R3,[R4,#-0x30]
        putWord(32'h114, 32'hE28F5000);   // ADD R5,R15,#0
        putWord(32'h118, 32'hE0836005);   // ADD R6,R3,R5
        putWord(32'h11C, 32'hE5806014);   // STR R6,[R0,#0x14]
        putWord(32'h120, 32'hEC000000);   // halt
        sb.delete();
        expFetch(32'h100, -1);
        expFetch(32'h104, 7);
        expWrite(32'h008, 32'h0000_0005, 6);
        expFetch(32'h108, 4);
        expRead(32'h008, 6);
        expFetch(32'h10C, 5);
        expFetch(32'h110, 7);
        expWrite(32'h010, 32'h0000_0005, 6);
        expFetch(32'h114, 4);
        expFetch(32'h118, 7);
        expFetch(32'h11C, 7);
        expWrite(32'h014, 32'h0000_0121, 6);
        expFetch(32'h120, 4);
        applyStimulus(3, 1'b0);
        waitHalt("p2_halt");
        checkOutput("p2_pc_halt", pc, 32'h124);
        checkOutput("p2_flags", {28'b0, flags}, 32'd0);
        checkOutput("p2_sb_empty", sb.size(), 32'd0);

        // Program 3: ALU write to R15, then a branch-to-self at 0x20
        clearMem();
        putWord(32'h100, 32'hE380F020);   // ORR R15,R0,#0x20
        putWord(32'h020, 32'hEAFFFFFE);   // B .
        sb.delete();
        expFetch(32'h100, -1);
        expFetch(32'h020, 4);
        expFetch(32'h020, 3);
        expFetch(32'h020, 3);
        expFetch(32'h020, 3);
        applyStimulus(0, 1'b0);
        waitFetches(5, "p3_wait_loop");
        checkOutput("p3_pc_loop", pc, 32'h20);
        checkOutput("p3_state_loop", {28'b0, state}, 32'd0);
        checkOutput("p3_sb_empty", sb.size(), 32'd0);

        // Async reset during a fetch that never completes
        sb.delete();
        applyStimulus(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1) break;
        end
        checkOutput("p4_req_before", {31'b0, mem_req}, 32'd1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("p4_req_dropped", {31'b0, mem_req}, 32'd0);
        checkOutput("p4_pc_reset", pc, RPC);
        checkOutput("p4_state_reset", {28'b0, state}, 32'd0);
        checkOutput("p4_halted_reset", {31'b0, halted}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
